// File: rtl/tdm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_pkg
//  Description : Shared constants and types for the TDM demux collector.
//  Revision    : 1.0 - initial release
// ============================================================================
package tdm_pkg;

    localparam int NUM_CH = 4;

    typedef logic [1:0] slot_t;

    localparam slot_t SLOT0 = 2'b00;
    localparam slot_t SLOT1 = 2'b01;
    localparam slot_t SLOT2 = 2'b10;
    localparam slot_t SLOT3 = 2'b11;

    // Bit-counter width; a 2-bit word still needs one counter bit.
    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tdm_chan_shreg.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_chan_shreg
//  Description : Per-channel serial-to-parallel shift register, MSB first.
//  Revision    : 1.0 - initial release
// ============================================================================
module tdm_chan_shreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             serial_in,
    output logic [WIDTH-1:0] par_out
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_out <= '0;
        end else if (shift_en) begin
            par_out <= {par_out[WIDTH-2:0], serial_in};
        end
    end

endmodule
`default_nettype wire

// File: rtl/tdm_demux_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_demux_collector
//  Description : Drives 1:4 demux selects round-robin, assembles each channel
//                into a word and presents whole frames over valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module tdm_demux_collector
    import tdm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             y0,
    input  logic             y1,
    input  logic             y2,
    input  logic             y3,
    output logic             s1,
    output logic             s0,
    input  logic             out_ready,
    output logic             frame_valid,
    output logic [WIDTH-1:0] ch0,
    output logic [WIDTH-1:0] ch1,
    output logic [WIDTH-1:0] ch2,
    output logic [WIDTH-1:0] ch3,
    output logic             overrun
);

    localparam int            BW       = cnt_width(WIDTH);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    slot_t             slot;
    logic [BW-1:0]     bit_cnt;
    logic [NUM_CH-1:0] y_vec;
    logic [WIDTH-1:0]  sr [NUM_CH];
    logic [WIDTH-1:0]  ch3_word;
    logic              frame_done;

    assign y_vec   = {y3, y2, y1, y0};
    assign {s1, s0} = slot;

    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
            tdm_chan_shreg #(
                .WIDTH (WIDTH)
            ) u_shreg (
                .clk       (clk),
                .rst       (rst),
                .shift_en  (en && (slot == slot_t'(k))),
                .serial_in (y_vec[k]),
                .par_out   (sr[k])
            );
        end
    endgenerate

    assign frame_done = en && (slot == SLOT3) && (bit_cnt == BIT_LAST);

    // Channel 3's last bit is still in flight on the completing edge.
    assign ch3_word = {sr[3][WIDTH-2:0], y3};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot    <= SLOT0;
            bit_cnt <= '0;
        end else if (en) begin
            slot <= slot + 2'd1;
            if (slot == SLOT3) begin
                bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch0         <= '0;
            ch1         <= '0;
            ch2         <= '0;
            ch3         <= '0;
            frame_valid <= 1'b0;
            overrun     <= 1'b0;
        end else if (frame_done) begin
            if (!frame_valid || out_ready) begin
                ch0         <= sr[0];
                ch1         <= sr[1];
                ch2         <= sr[2];
                ch3         <= ch3_word;
                frame_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (frame_valid && out_ready) begin
            frame_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tdm_demux_collector
//  Description : Scoreboard bench for tdm_demux_collector (WIDTH=8 and 2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tdm_demux_collector;

    localparam int WIDTH = 8;
    localparam int FLEN  = 4 * WIDTH;

    logic clk = 1'b0;
    logic rst, en, out_ready, d;
    logic y0, y1, y2, y3, s1, s0, frame_valid, overrun;
    logic [WIDTH-1:0] ch0, ch1, ch2, ch3;

    logic en2, rdy2, d2;
    logic y20, y21, y22, y23, s21, s20, fv2, ov2;
    logic [1:0] c20, c21, c22, c23;

    always #5 clk = ~clk;

    // Behavioural demux: the serial bit goes to whichever output is selected.
    assign y0 = ({s1, s0} == 2'd0) ? d : 1'b0;
    assign y1 = ({s1, s0} == 2'd1) ? d : 1'b0;
    assign y2 = ({s1, s0} == 2'd2) ? d : 1'b0;
    assign y3 = ({s1, s0} == 2'd3) ? d : 1'b0;
    assign y20 = ({s21, s20} == 2'd0) ? d2 : 1'b0;
    assign y21 = ({s21, s20} == 2'd1) ? d2 : 1'b0;
    assign y22 = ({s21, s20} == 2'd2) ? d2 : 1'b0;
    assign y23 = ({s21, s20} == 2'd3) ? d2 : 1'b0;

    tdm_demux_collector #(.WIDTH(WIDTH)) u_dut (
        .clk(clk), .rst(rst), .en(en),
        .y0(y0), .y1(y1), .y2(y2), .y3(y3),
        .s1(s1), .s0(s0), .out_ready(out_ready), .frame_valid(frame_valid),
        .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3), .overrun(overrun)
    );

    tdm_demux_collector #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .en(en2),
        .y0(y20), .y1(y21), .y2(y22), .y3(y23),
        .s1(s21), .s0(s20), .out_ready(rdy2), .frame_valid(fv2),
        .ch0(c20), .ch1(c21), .ch2(c22), .ch3(c23), .overrun(ov2)
    );

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model: position in frame, held/overrun flags, frame data.
    int                      m_cnt;
    bit                      m_fv, m_ov;
    logic [WIDTH-1:0]        cur [4];
    logic [4*WIDTH-1:0]      exp_q [$];
    logic [4*WIDTH-1:0]      dir_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_frame();
        logic [4*WIDTH-1:0] f;
        if (dir_q.size() > 0) f = dir_q.pop_front();
        else f = {$urandom, $urandom};
        for (int k = 0; k < 4; k++) cur[k] = f[k*WIDTH +: WIDTH];
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_fv  = 1'b0;
        m_ov  = 1'b0;
        exp_q.delete();
        next_frame();
    endtask

    // One clock: drive inputs, predict the edge, then check control outputs.
    task automatic cycle(input bit e, input bit r);
        en        = e;
        out_ready = r;
        if (e) d = cur[m_cnt % 4][WIDTH - 1 - m_cnt / 4];
        else   d = 1'($urandom);
        if (e && m_cnt == FLEN - 1) begin
            if (!m_fv || r) begin
                exp_q.push_back({cur[3], cur[2], cur[1], cur[0]});
                m_fv = 1'b1;
            end else begin
                m_ov = 1'b1;
            end
            next_frame();
            m_cnt = 0;
        end else begin
            if (m_fv && r) m_fv = 1'b0;
            if (e) m_cnt++;
        end
        @(posedge clk);
        #1;
        check("frame_valid", 32'(frame_valid), 32'(m_fv));
        check("overrun", 32'(overrun), 32'(m_ov));
        check("select", 32'({s1, s0}), 32'(m_cnt % 4));
    endtask

    // mode 0: ready always 1, mode 1: ready always 0, mode 2: ready only on completing cycle
    task automatic run_frame(input int mode);
        for (int i = 0; i < FLEN; i++) begin
            cycle(1'b1, (mode == 0) || (mode == 2 && i == FLEN - 1));
        end
    endtask

    // Monitor: every accepted frame must match the oldest expected one.
    always @(negedge clk) begin
        if (!rst && frame_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_frame", 32'(1), 32'(0));
            end else begin
                logic [4*WIDTH-1:0] e;
                e = exp_q.pop_front();
                check("ch0", 32'(ch0), 32'(e[0*WIDTH +: WIDTH]));
                check("ch1", 32'(ch1), 32'(e[1*WIDTH +: WIDTH]));
                check("ch2", 32'(ch2), 32'(e[2*WIDTH +: WIDTH]));
                check("ch3", 32'(ch3), 32'(e[3*WIDTH +: WIDTH]));
            end
        end
    end

    task automatic check_reset_outputs();
        check("rst_frame_valid", 32'(frame_valid), 32'(0));
        check("rst_overrun", 32'(overrun), 32'(0));
        check("rst_select", 32'({s1, s0}), 32'(0));
        check("rst_ch", 32'({ch0, ch1, ch2, ch3}), 32'(0));
    endtask

    initial begin
        logic [7:0] seq;
        rst = 1'b1; en = 1'b0; out_ready = 1'b0; d = 1'b0;
        en2 = 1'b0; rdy2 = 1'b0; d2 = 1'b0;
        dir_q.push_back({8'h00, 8'hFF, 8'h3C, 8'hA5});
        dir_q.push_back({8'hEF, 8'hBE, 8'hAD, 8'hDE});
        dir_q.push_back({8'h01, 8'hEE, 8'hFF, 8'hC0});
        dir_q.push_back({8'h44, 8'h33, 8'h22, 8'h11});
        dir_q.push_back({8'h88, 8'h77, 8'h66, 8'h55});
        model_reset();
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        run_frame(0);           // A5/3C/FF/00 streamed with ready held high
        cycle(1'b0, 1'b1);      // held exactly one cycle, then consumed
        run_frame(1);           // DE.. held
        run_frame(2);           // C0.. loaded on the same edge DE.. is taken
        cycle(1'b0, 1'b1);
        run_frame(1);           // 11.. held
        run_frame(1);           // 55.. dropped, overrun set
        cycle(1'b0, 1'b1);
        check("ch0_after_accept", 32'(ch0), 32'(8'h11));

        for (int i = 0; i < 500; i++) begin
            cycle(($urandom % 4) != 0, 1'($urandom));
        end
        for (int i = 0; i < FLEN && m_fv; i++) cycle(1'b0, 1'b1);

        // Mid-frame asynchronous reset at slot 2, bit 5.
        for (int i = 0; i < 2 * FLEN && m_cnt != 22; i++) cycle(1'b1, 1'b1);
        check("pre_reset_pos", 32'(m_cnt), 32'(22));
        rst = 1'b1;
        en  = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_frame(0);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);

        // WIDTH=2 build: ch0..ch3 = 10, 01, 11, 00 (MSBs of all slots first).
        seq = 8'b1010_0110;
        for (int i = 0; i < 8; i++) begin
            en2  = 1'b1;
            rdy2 = 1'b1;
            d2   = seq[7 - i];
            @(posedge clk);
            #1;
            check("w2_select", 32'({s21, s20}), 32'((i + 1) % 4));
            check("w2_frame_valid", 32'(fv2), 32'(i == 7));
        end
        en2 = 1'b0;
        check("w2_ch0", 32'(c20), 32'(2'b10));
        check("w2_ch1", 32'(c21), 32'(2'b01));
        check("w2_ch2", 32'(c22), 32'(2'b11));
        check("w2_ch3", 32'(c23), 32'(2'b00));
        check("w2_overrun", 32'(ov2), 32'(0));
        @(posedge clk);
        #1;
        check("w2_accepted", 32'(fv2), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
